// File: rtl/mips_pkg.sv
// Shared types and helpers for the MIPS core hazard logic.
package mips_pkg;

    // Multiply/divide sequencer states
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    // Execute-stage operand forwarding selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Default multiply/divide busy latencies and counter width
    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 32;
    localparam int CNT_W_DEF   = 6;

    // Register 0 is hardwired to zero, so it never creates a dependency
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

    // Memory stage wins over writeback; otherwise read the register file
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] dst_m, input logic en_m,
                                           input logic [4:0] dst_w, input logic en_w);
        if (en_m && reg_match(src, dst_m))
            return FWD_MEM;
        else if (en_w && reg_match(src, dst_w))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle between the datapath and the hazard controller.
// There is no handshake here: every signal is a per-cycle level; inputs are
// valid every cycle and outputs are combinational or registered levels that
// the datapath consumes in the same cycle (md_done_o is a one-cycle pulse).
interface hazard_ctrl_if import mips_pkg::*; ();
    logic [4:0]  rs_id5;
    logic [4:0]  rt_id5;
    logic        branch_id;
    logic        md_op_id;
    logic [4:0]  rs_ie5;
    logic [4:0]  rt_ie5;
    logic [4:0]  dst_reg_ie5;
    logic [4:0]  dst_reg_im5;
    logic [4:0]  dst_reg_iwb5;
    logic        enable_wreg_ie;
    logic        enable_wreg_im;
    logic        enable_wreg_iwb;
    logic        mem_to_reg_ie;
    logic        mem_to_reg_im;
    logic        md_start_ie;
    logic        md_is_div_ie;

    logic        stall_f_o;
    logic        stall_d_o;
    logic        flush_e_o;
    logic        forward_rd1_od;
    logic        forward_rd2_od;
    logic [1:0]  forward_a_oe2;
    logic [1:0]  forward_b_oe2;
    logic        md_busy_o;
    logic        md_done_o;
    logic [31:0] stall_cnt_o32;
    md_state_t   md_state_o;      // debug view of the MD sequencer state

    // Datapath side
    modport master (
        output rs_id5, rt_id5, branch_id, md_op_id, rs_ie5, rt_ie5,
               dst_reg_ie5, dst_reg_im5, dst_reg_iwb5,
               enable_wreg_ie, enable_wreg_im, enable_wreg_iwb,
               mem_to_reg_ie, mem_to_reg_im, md_start_ie, md_is_div_ie,
        input  stall_f_o, stall_d_o, flush_e_o, forward_rd1_od, forward_rd2_od,
               forward_a_oe2, forward_b_oe2, md_busy_o, md_done_o,
               stall_cnt_o32, md_state_o
    );

    // Hazard controller side
    modport slave (
        input  rs_id5, rt_id5, branch_id, md_op_id, rs_ie5, rt_ie5,
               dst_reg_ie5, dst_reg_im5, dst_reg_iwb5,
               enable_wreg_ie, enable_wreg_im, enable_wreg_iwb,
               mem_to_reg_ie, mem_to_reg_im, md_start_ie, md_is_div_ie,
        output stall_f_o, stall_d_o, flush_e_o, forward_rd1_od, forward_rd2_od,
               forward_a_oe2, forward_b_oe2, md_busy_o, md_done_o,
               stall_cnt_o32, md_state_o
    );
endinterface

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer: IDLE -> BUSY (LAT cycles) -> DONE (1 cycle).
// CNT_W must be wide enough to hold max(MUL_LAT, DIV_LAT) - 1.
module md_sequencer import mips_pkg::*; #(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      md_start_i,
    input  logic      md_is_div_i,
    output md_state_t state_o,
    output logic      md_busy_o,
    output logic      md_done_o
);
    // Counter preload so BUSY lasts exactly LAT cycles (counts LAT-1 down to 0)
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    md_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;

    // FSM and down-counter; a start request outside IDLE is ignored
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (md_start_i) begin
                        state_q <= MD_BUSY;
                        cnt_q   <= md_is_div_i ? DIV_LOAD : MUL_LOAD;
                    end
                end
                MD_BUSY: begin
                    if (cnt_q == '0)
                        state_q <= MD_DONE;
                    else
                        cnt_q <= cnt_q - CNT_W'(1);
                end
                MD_DONE: state_q <= MD_IDLE;
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    // Status flags decoded straight from the state register
    always_comb begin
        state_o   = state_q;
        md_busy_o = (state_q == MD_BUSY);
        md_done_o = (state_q == MD_DONE);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load/branch/MD stalls,
// and a saturating stall-cycle counter for performance measurement.
module hazard_ctrl import mips_pkg::*; #(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    hazard_ctrl_if.slave  hz
);
    md_state_t   md_state;
    logic        md_busy;
    logic        md_done;
    logic        lw_stall;
    logic        br_stall;
    logic        md_stall;
    logic        stall;
    logic [31:0] stall_cnt_q;

    md_sequencer #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_md_seq (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .md_start_i  (hz.md_start_ie),
        .md_is_div_i (hz.md_is_div_ie),
        .state_o     (md_state),
        .md_busy_o   (md_busy),
        .md_done_o   (md_done)
    );

    // Forwarding selects: purely combinational, deliberately not gated by reset
    always_comb begin
        hz.forward_rd1_od = hz.enable_wreg_im & reg_match(hz.rs_id5, hz.dst_reg_im5);
        hz.forward_rd2_od = hz.enable_wreg_im & reg_match(hz.rt_id5, hz.dst_reg_im5);
        hz.forward_a_oe2  = fwd_sel(hz.rs_ie5, hz.dst_reg_im5, hz.enable_wreg_im,
                                    hz.dst_reg_iwb5, hz.enable_wreg_iwb);
        hz.forward_b_oe2  = fwd_sel(hz.rt_ie5, hz.dst_reg_im5, hz.enable_wreg_im,
                                    hz.dst_reg_iwb5, hz.enable_wreg_iwb);
    end

    // Stall sources merge into one stall, suppressed while in reset
    always_comb begin
        lw_stall = hz.mem_to_reg_ie &
                   (reg_match(hz.rs_id5, hz.dst_reg_ie5) | reg_match(hz.rt_id5, hz.dst_reg_ie5));
        br_stall = hz.branch_id &
                   ((hz.enable_wreg_ie &
                     (reg_match(hz.rs_id5, hz.dst_reg_ie5) | reg_match(hz.rt_id5, hz.dst_reg_ie5))) |
                    (hz.mem_to_reg_im &
                     (reg_match(hz.rs_id5, hz.dst_reg_im5) | reg_match(hz.rt_id5, hz.dst_reg_im5))));
        // HI/LO access waits until the sequencer is back in IDLE (DONE included)
        md_stall = hz.md_op_id & ((md_state != MD_IDLE) | hz.md_start_ie);
        stall    = ~rst_i & (lw_stall | br_stall | md_stall);
    end

    // Saturating count of stalled decode cycles
    always_ff @(posedge clk_i) begin
        if (rst_i)
            stall_cnt_q <= '0;
        else if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    // Drive the remaining interface outputs
    always_comb begin
        hz.stall_f_o     = stall;
        hz.stall_d_o     = stall;
        hz.flush_e_o     = stall;
        hz.md_busy_o     = md_busy;
        hz.md_done_o     = md_done;
        hz.md_state_o    = md_state;
        hz.stall_cnt_o32 = stall_cnt_q;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl.
module tb_hazard_ctrl;
    import mips_pkg::*;

    localparam int W = 41;

    logic clk;
    logic rst;

    hazard_ctrl_if hz();

    hazard_ctrl #(
        .MUL_LAT (4),
        .DIV_LAT (32),
        .CNT_W   (6)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (hz)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_cmp = 0;
    int           n_err = 0;

    task automatic check(input string nm, input string fld,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %0h expected %0h at %0t", nm, fld, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clr();
        hz.rs_id5 = '0;          hz.rt_id5 = '0;
        hz.branch_id = 1'b0;     hz.md_op_id = 1'b0;
        hz.rs_ie5 = '0;          hz.rt_ie5 = '0;
        hz.dst_reg_ie5 = '0;     hz.dst_reg_im5 = '0;   hz.dst_reg_iwb5 = '0;
        hz.enable_wreg_ie = 1'b0; hz.enable_wreg_im = 1'b0; hz.enable_wreg_iwb = 1'b0;
        hz.mem_to_reg_ie = 1'b0; hz.mem_to_reg_im = 1'b0;
        hz.md_start_ie = 1'b0;   hz.md_is_div_ie = 1'b0;
    endtask

    // Queue the expected outputs for the current cycle, then advance one clock
    task automatic step(input string nm, input logic stall, input logic frd1, input logic frd2,
                        input logic [1:0] fa, input logic [1:0] fb,
                        input logic busy, input logic done, input logic [31:0] cnt);
        exp_q.push_back({stall, frd1, frd2, fa, fb, busy, done, cnt});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            string        nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check(nm, "stall_f",  {31'd0, hz.stall_f_o},      {31'd0, e[40]});
            check(nm, "stall_d",  {31'd0, hz.stall_d_o},      {31'd0, e[40]});
            check(nm, "flush_e",  {31'd0, hz.flush_e_o},      {31'd0, e[40]});
            check(nm, "fwd_rd1",  {31'd0, hz.forward_rd1_od}, {31'd0, e[39]});
            check(nm, "fwd_rd2",  {31'd0, hz.forward_rd2_od}, {31'd0, e[38]});
            check(nm, "fwd_a",    {30'd0, hz.forward_a_oe2},  {30'd0, e[37:36]});
            check(nm, "fwd_b",    {30'd0, hz.forward_b_oe2},  {30'd0, e[35:34]});
            check(nm, "md_busy",  {31'd0, hz.md_busy_o},      {31'd0, e[33]});
            check(nm, "md_done",  {31'd0, hz.md_done_o},      {31'd0, e[32]});
            check(nm, "stall_cnt", hz.stall_cnt_o32,          e[31:0]);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        clr();
        repeat (2) @(posedge clk);
        #1;

        // Reset: registered outputs cleared, stall forced low, forwarding still live
        hz.mem_to_reg_ie = 1'b1; hz.dst_reg_ie5 = 5'd8; hz.rs_id5 = 5'd8;
        hz.rs_ie5 = 5'd3; hz.dst_reg_im5 = 5'd3; hz.enable_wreg_im = 1'b1;
        step("rst_gate", 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 32'd0);
        rst = 1'b0;

        // Load-use hazards
        clr(); hz.mem_to_reg_ie = 1'b1; hz.dst_reg_ie5 = 5'd8; hz.rs_id5 = 5'd8;
        step("lu_rs", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0);
        clr(); hz.mem_to_reg_ie = 1'b1; hz.dst_reg_ie5 = 5'd0; hz.rs_id5 = 5'd0;
        step("lu_r0", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 32'd1);
        clr(); hz.mem_to_reg_ie = 1'b1; hz.dst_reg_ie5 = 5'd5; hz.rt_id5 = 5'd5;
        step("lu_rt", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 32'd1);
        clr(); hz.enable_wreg_ie = 1'b1; hz.dst_reg_ie5 = 5'd5; hz.rt_id5 = 5'd5;
        step("lu_noload", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 32'd2);

        // Execute-stage forwarding
        clr(); hz.rs_ie5 = 5'd9; hz.dst_reg_im5 = 5'd9; hz.dst_reg_iwb5 = 5'd9;
        hz.enable_wreg_im = 1'b1; hz.enable_wreg_iwb = 1'b1;
        step("fwd_mem", 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 32'd2);
        hz.enable_wreg_im = 1'b0;
        step("fwd_wb", 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 32'd2);
        clr(); hz.rs_ie5 = 5'd6; hz.rt_ie5 = 5'd7; hz.dst_reg_im5 = 5'd6; hz.dst_reg_iwb5 = 5'd7;
        hz.enable_wreg_im = 1'b1; hz.enable_wreg_iwb = 1'b1;
        step("fwd_b_wb", 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0, 1'b0, 32'd2);
        clr(); hz.enable_wreg_im = 1'b1; hz.enable_wreg_iwb = 1'b1;
        step("fwd_r0", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 32'd2);

        // Branch compare hazards and decode forwarding
        clr(); hz.branch_id = 1'b1; hz.rt_id5 = 5'd4; hz.enable_wreg_ie = 1'b1; hz.dst_reg_ie5 = 5'd4;
        step("br_ex", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 32'd2);
        clr(); hz.branch_id = 1'b1; hz.rt_id5 = 5'd4; hz.enable_wreg_im = 1'b1; hz.dst_reg_im5 = 5'd4;
        step("br_mem_alu", 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 32'd3);
        hz.mem_to_reg_im = 1'b1;
        step("br_mem_load", 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 32'd3);
        clr(); hz.branch_id = 1'b1; hz.rs_id5 = 5'd8; hz.mem_to_reg_ie = 1'b1;
        hz.enable_wreg_ie = 1'b1; hz.dst_reg_ie5 = 5'd8;
        step("br_and_lw", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 32'd4);
        clr(); hz.branch_id = 1'b1; hz.rt_id5 = 5'd4; hz.dst_reg_ie5 = 5'd4;
        step("br_noen", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 32'd5);
        clr(); hz.rs_id5 = 5'd12; hz.dst_reg_im5 = 5'd12; hz.enable_wreg_im = 1'b1;
        step("frd1", 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 32'd5);

        // Multiply with dependent HI/LO read held in decode
        clr(); hz.md_start_ie = 1'b1; hz.md_op_id = 1'b1;
        step("mul_start", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 32'd5);
        clr(); hz.md_op_id = 1'b1;
        for (int i = 0; i < 4; i++)
            step("mul_busy", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 32'd6 + 32'(i));
        step("mul_done", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 32'd10);
        step("mul_issue", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 32'd11);

        // Divide aborted by reset in its tenth busy cycle
        clr(); hz.md_start_ie = 1'b1; hz.md_is_div_ie = 1'b1;
        step("div_start", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 32'd11);
        clr();
        for (int i = 0; i < 9; i++)
            step("div_busy", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 32'd11);
        rst = 1'b1;
        step("div_rst", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 32'd11);
        rst = 1'b0;
        step("div_idle0", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0);
        hz.md_op_id = 1'b1;
        step("div_idle1", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0);

        // Saturation from a preloaded count
        clr();
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        hz.mem_to_reg_ie = 1'b1; hz.dst_reg_ie5 = 5'd8; hz.rs_id5 = 5'd8;
        step("sat_pre", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 32'hFFFF_FFFE);
        step("sat_max", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 32'hFFFF_FFFF);
        step("sat_hold", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 32'hFFFF_FFFF);
        clr();
        step("sat_idle", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 32'hFFFF_FFFF);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
